// File: rtl/bilat_frame_ctrl_if.sv
// bilat_frame_ctrl_if: pixel stream between the gray source, the frame controller and the 3x3 filter
//   pix_valid/pix_data/pix_ready : source pixel handshake (controller is the slave)
//   filt_rst                     : reset pulse to the filter line buffers and window
//   gray_valid/gray              : registered pixel strobe and data to the filter
interface bilat_frame_ctrl_if;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;
    logic       filt_rst;
    logic       gray_valid;
    logic [7:0] gray;
    modport master (output pix_valid, pix_data, input pix_ready, filt_rst, gray_valid, gray);
    modport slave  (input pix_valid, pix_data, output pix_ready, filt_rst, gray_valid, gray);
endinterface

// File: rtl/bilat_frame_ctrl.sv
// bilat_frame_ctrl: frame sequencer feeding a 3x3 bilateral filter (IDLE/PRIME/STREAM/FLUSH/DONE)
//   clk, rst          : clock and synchronous active-high reset
//   start, abort      : frame start (sampled in IDLE) and cancel (any state, wins over start)
//   pix               : slave side of bilat_frame_ctrl_if (source handshake, filt_rst, gray stream)
//   busy, frame_done  : not-IDLE flag and one-cycle completion pulse
//   cur_row, cur_col  : position of the last pixel driven on gray
//   frame_cnt         : completed frames, wraps at 16 bits
//   BILAT_CTRL_FLUSH_EN : when defined, IMAGE_WIDTH+1 zero beats flush the filter after the last pixel
module bilat_frame_ctrl #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    bilat_frame_ctrl_if.slave        pix,
    output logic                     busy,
    output logic                     frame_done,
    output logic [11:0]              cur_row,
    output logic [11:0]              cur_col,
    output logic [15:0]              frame_cnt
);
    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        STREAM,
`ifdef BILAT_CTRL_FLUSH_EN
        FLUSH,
`endif
        DONE
    } state_t;
    localparam logic [11:0] COL_LAST = 12'(IMAGE_WIDTH - 1);
    localparam logic [11:0] ROW_LAST = 12'(IMAGE_HEIGHT - 1);
`ifdef BILAT_CTRL_FLUSH_EN
    localparam logic [12:0] FLUSH_LAST = 13'(IMAGE_WIDTH);
    logic [12:0] flush_cnt;
`endif
    state_t      state;
    logic [11:0] row, col;
    logic        accept, col_wrap, last_pix;
    assign pix.pix_ready = (state == STREAM);
    assign accept        = pix.pix_valid & pix.pix_ready;
    assign col_wrap      = (col == COL_LAST);
    assign last_pix      = accept && col_wrap && (row == ROW_LAST);
    // row/col hold the position of the next beat; cur_row/cur_col follow gray with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            frame_cnt      <= '0;
            cur_row        <= '0;
            cur_col        <= '0;
            row            <= '0;
            col            <= '0;
            pix.filt_rst   <= 1'b0;
            pix.gray_valid <= 1'b0;
            pix.gray       <= '0;
`ifdef BILAT_CTRL_FLUSH_EN
            flush_cnt      <= '0;
`endif
        end else begin
            pix.gray_valid <= 1'b0;
            pix.filt_rst   <= 1'b0;
            frame_done     <= 1'b0;
            if (abort && state != IDLE) begin
                state        <= IDLE;
                busy         <= 1'b0;
                pix.filt_rst <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        state        <= PRIME;
                        busy         <= 1'b1;
                        pix.filt_rst <= 1'b1;
                        row          <= '0;
                        col          <= '0;
                        cur_row      <= '0;
                        cur_col      <= '0;
                    end
                    PRIME: state <= STREAM;
                    STREAM: if (accept) begin
                        pix.gray_valid <= 1'b1;
                        pix.gray       <= pix.pix_data;
                        cur_row        <= row;
                        cur_col        <= col;
                        col            <= col_wrap ? '0 : col + 12'd1;
                        row            <= row + {11'b0, col_wrap};
`ifdef BILAT_CTRL_FLUSH_EN
                        flush_cnt      <= '0;
                        if (last_pix) state <= FLUSH;
`else
                        if (last_pix) state <= DONE;
`endif
                    end
`ifdef BILAT_CTRL_FLUSH_EN
                    FLUSH: begin
                        pix.gray_valid <= 1'b1;
                        pix.gray       <= '0;
                        cur_row        <= row;
                        cur_col        <= col;
                        col            <= col_wrap ? '0 : col + 12'd1;
                        row            <= row + {11'b0, col_wrap};
                        flush_cnt      <= flush_cnt + 13'd1;
                        if (flush_cnt == FLUSH_LAST) state <= DONE;
                    end
`endif
                    DONE: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bilat_frame_ctrl.sv
// tb_bilat_frame_ctrl: directed checks of bilat_frame_ctrl with a 4x3 image
module tb_bilat_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic        busy, frame_done;
    logic [11:0] cur_row, cur_col;
    logic [15:0] frame_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;
    bilat_frame_ctrl_if bus();
    bilat_frame_ctrl #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pix(bus),
        .busy(busy), .frame_done(frame_done), .cur_row(cur_row), .cur_col(cur_col),
        .frame_cnt(frame_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        chk("prime_busy", busy, 1);
        chk("prime_filt_rst", bus.filt_rst, 1);
        chk("prime_ready", bus.pix_ready, 0);
        chk("prime_row", cur_row, 0);
        chk("prime_col", cur_col, 0);
        start = 1'b0;
        @(negedge clk);
        chk("stream_filt_rst", bus.filt_rst, 0);
        chk("stream_ready", bus.pix_ready, 1);
        chk("stream_busy", busy, 1);
    endtask
    task automatic run_frame(input logic [15:0] exp_cnt, input logic hold_start);
        start = hold_start;
        bus.pix_valid = 1'b1;
        bus.pix_data = 8'd0;
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            chk("beat_valid", bus.gray_valid, 1);
            chk("beat_gray", bus.gray, i - 1);
            chk("beat_row", cur_row, (i - 1) / 4);
            chk("beat_col", cur_col, (i - 1) % 4);
            bus.pix_data = 8'(i);
        end
        @(negedge clk);
        chk("last_valid", bus.gray_valid, 1);
        chk("last_gray", bus.gray, 11);
        chk("last_row", cur_row, 2);
        chk("last_col", cur_col, 3);
        chk("last_busy", busy, 1);
        chk("last_done", frame_done, 0);
        bus.pix_valid = 1'b0;
        start = 1'b0;
`ifdef BILAT_CTRL_FLUSH_EN
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("flush_valid", bus.gray_valid, 1);
            chk("flush_gray", bus.gray, 0);
            chk("flush_done", frame_done, 0);
        end
        chk("flush_row", cur_row, 4);
        chk("flush_col", cur_col, 0);
`endif
        @(negedge clk);
        chk("done_pulse", frame_done, 1);
        chk("done_cnt", frame_cnt, exp_cnt);
        chk("done_valid", bus.gray_valid, 0);
        chk("done_busy", busy, 0);
        @(negedge clk);
        chk("done_clear", frame_done, 0);
        chk("idle_busy", busy, 0);
    endtask
    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.pix_ready, 0);
        chk("rst_filt", bus.filt_rst, 0);
        chk("rst_gv", bus.gray_valid, 0);
        chk("rst_gray", bus.gray, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_pos", {cur_row, cur_col}, 0);
        chk("rst_cnt", frame_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy0", busy, 0);
        start_frame();
        run_frame(16'd1, 1'b0);
        start_frame();
        for (int j = 0; j < 4; j++) begin
            bus.pix_valid = (j % 2 == 0);
            bus.pix_data = 8'(50 + j);
            @(negedge clk);
            chk("hole_valid", bus.gray_valid, (j % 2 == 0));
            if (j % 2 == 0) chk("hole_gray", bus.gray, 50 + j);
            chk("hole_col", cur_col, j / 2);
        end
        for (int m = 0; m < 4; m++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data = 8'(60 + m);
            @(negedge clk);
            chk("pre_abort_gray", bus.gray, 60 + m);
        end
        chk("pre_abort_row", cur_row, 1);
        chk("pre_abort_col", cur_col, 1);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_filt", bus.filt_rst, 1);
        chk("abort_gv", bus.gray_valid, 0);
        chk("abort_ready", bus.pix_ready, 0);
        chk("abort_done", frame_done, 0);
        chk("abort_cnt", frame_cnt, 1);
        abort = 1'b0;
        bus.pix_valid = 1'b0;
        @(negedge clk);
        chk("abort_filt_clr", bus.filt_rst, 0);
        chk("abort_done2", frame_done, 0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        chk("both_busy", busy, 0);
        chk("both_filt", bus.filt_rst, 0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("both_idle", busy, 0);
        start_frame();
        run_frame(16'd2, 1'b1);
        start_frame();
        bus.pix_valid = 1'b1;
        bus.pix_data = 8'h33;
        repeat (2) @(negedge clk);
        chk("mid_gv", bus.gray_valid, 1);
        rst = 1'b1;
        bus.pix_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gv", bus.gray_valid, 0);
        chk("mid_rst_col", cur_col, 0);
        chk("mid_rst_cnt", frame_cnt, 0);
        chk("mid_rst_done", frame_done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", frame_done, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bilat_frame_ctrl.md
BILAT_FRAME_CTRL -- requirements
Module: bilat_frame_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 320: pixels per line (2..4095).
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 240: lines per frame (2..4095).
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  frame-start request; sampled only in IDLE.
REQ-007 abort  input  1  cancel the current frame; honoured in any state.
REQ-008 pix_valid  input  1  source pixel valid.
REQ-009 pix_data  input  8  source gray pixel.
REQ-010 pix_ready  output  1  controller accepts a pixel this cycle.
REQ-011 filt_rst  output  1  reset pulse to the 3x3 filter (clears its line buffers and window).
REQ-012 gray_valid  output  1  pixel strobe to the filter.
REQ-013 gray  output  8  pixel to the filter.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 frame_done  output  1  one-cycle pulse at frame completion.
REQ-016 cur_row  output  12  row index of the last pixel driven on gray.
REQ-017 cur_col  output  12  column index of the last pixel driven on gray.
REQ-018 frame_cnt  output  16  count of completed frames.

Function
REQ-019 States SHALL be IDLE, PRIME, STREAM, FLUSH and DONE.
REQ-020 Transitions: IDLE->PRIME on start; PRIME->STREAM after exactly 1 cycle; STREAM->FLUSH after the final accepted pixel; FLUSH->DONE after IMAGE_WIDTH+1 flush beats; DONE->IDLE after 1 cycle.
REQ-021 filt_rst SHALL be high for exactly the single PRIME cycle.
REQ-022 pix_ready SHALL be high only in STREAM and SHALL be combinational from state.
REQ-023 A pixel is accepted when pix_valid and pix_ready are both high.
REQ-024 gray_valid and gray SHALL be registered, with 1-cycle latency from acceptance; gray_valid is low when no pixel is accepted.
REQ-025 cur_col SHALL wrap from IMAGE_WIDTH-1 to 0 with cur_row+1. The pixel at (IMAGE_HEIGHT-1, IMAGE_WIDTH-1) ends STREAM.
REQ-026 In FLUSH, gray_valid SHALL be high every cycle with gray=0 for IMAGE_WIDTH+1 cycles; cur_row/cur_col continue counting.
REQ-027 In DONE, frame_done SHALL be high for 1 cycle and frame_cnt SHALL increment, wrapping 0xFFFF->0.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 On abort in any non-IDLE state, the next state SHALL be IDLE: gray_valid=0, filt_rst=1 for that one cycle, no frame_done, frame_cnt unchanged.
REQ-030 When start and abort arrive in the same IDLE cycle, abort SHALL win and the block stays in IDLE.
REQ-031 cur_row and cur_col SHALL clear to 0 on entry to PRIME.

Reset
REQ-032 On rst the block SHALL enter IDLE with every output 0: pix_ready, filt_rst, gray_valid, gray, busy, frame_done, cur_row, cur_col and frame_cnt.
REQ-033 rst mid-frame SHALL have the same effect as REQ-032; no frame_done is produced.

Configuration
REQ-034 Macro BILAT_CTRL_FLUSH_EN SHALL control the FLUSH state.
REQ-035 With BILAT_CTRL_FLUSH_EN defined, FLUSH SHALL behave as in REQ-026.
REQ-036 Without BILAT_CTRL_FLUSH_EN, FLUSH SHALL be absent and STREAM->DONE follows the final accepted pixel directly.

Verification (IMAGE_WIDTH=4, IMAGE_HEIGHT=3, BILAT_CTRL_FLUSH_EN defined unless stated)
REQ-037 Reset release, then start pulse -> busy=1 next cycle, filt_rst=1 for exactly 1 cycle, pix_ready=1 the cycle after.
REQ-038 12 pixels 0..11 with pix_valid held high -> 12 consecutive gray_valid beats carrying 0..11; then 5 zero beats; frame_done one cycle later; frame_cnt=1.
REQ-039 pix_valid toggled 1,0,1,0 -> gray_valid holes align 1 cycle later; cur_col holds across holes.
REQ-040 abort after 6 accepted pixels -> IDLE next cycle, filt_rst pulse, no frame_done, frame_cnt unchanged; a following start runs a full frame.
REQ-041 start with abort in the same IDLE cycle -> stays IDLE. start while in STREAM -> no effect.
REQ-042 With BILAT_CTRL_FLUSH_EN undefined, run 12 pixels -> frame_done 1 cycle after the last gray beat, with no zero beats.
